// File: rtl/alu_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
// Opcode encodings are the ones decoded by the shared alu datapath.
package alu_sched_pkg;
  localparam int WORD      = 8;
  localparam int OP_W      = 4;
  localparam int N_REQ_DEF = 2;
  localparam int PTR_W     = $clog2(N_REQ_DEF);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_SUM = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_AND = 4'h3;
  localparam logic [OP_W-1:0] OP_OR  = 4'h4;
  localparam logic [OP_W-1:0] OP_XOR = 4'h5;
  localparam logic [OP_W-1:0] OP_SHL = 4'h6;
  localparam logic [OP_W-1:0] OP_SHR = 4'h7;
endpackage

// File: rtl/alu_rr_scheduler_alu.sv
// Combinational ALU shared by the scheduler's requesters.
// Undefined opcodes yield result 0 with zero set and carry clear.
module alu
  import alu_sched_pkg::*;
#(
  parameter int WIDTH    = WORD,
  parameter int OP_WIDTH = OP_W
) (
  input  logic [WIDTH-1:0]    i_a,
  input  logic [WIDTH-1:0]    i_b,
  input  logic [OP_WIDTH-1:0] i_opcode,
  output logic [WIDTH-1:0]    o_result,
  output logic                o_zero,
  output logic                o_cf
);
  logic [WIDTH:0]   ext_s;
  logic [WIDTH-1:0] result_s;
  logic             cf_s;

  // Opcode decode; cf is carry for add, borrow for subtract, shifted-out bit for shifts
  always_comb begin
    ext_s    = '0;
    result_s = '0;
    cf_s     = 1'b0;
    case (i_opcode)
      OP_WIDTH'(OP_NOP): result_s = i_a;
      OP_WIDTH'(OP_SUM): begin
        ext_s    = {1'b0, i_a} + {1'b0, i_b};
        result_s = ext_s[WIDTH-1:0];
        cf_s     = ext_s[WIDTH];
      end
      OP_WIDTH'(OP_SUB): begin
        ext_s    = {1'b0, i_a} - {1'b0, i_b};
        result_s = ext_s[WIDTH-1:0];
        cf_s     = ext_s[WIDTH];
      end
      OP_WIDTH'(OP_AND): result_s = i_a & i_b;
      OP_WIDTH'(OP_OR):  result_s = i_a | i_b;
      OP_WIDTH'(OP_XOR): result_s = i_a ^ i_b;
      OP_WIDTH'(OP_SHL): begin
        result_s = {i_a[WIDTH-2:0], 1'b0};
        cf_s     = i_a[WIDTH-1];
      end
      OP_WIDTH'(OP_SHR): begin
        result_s = {1'b0, i_a[WIDTH-1:1]};
        cf_s     = i_a[0];
      end
      default: begin
        result_s = '0;
        cf_s     = 1'b0;
      end
    endcase
  end

  assign o_result = result_s;
  assign o_zero   = (result_s == '0);
  assign o_cf     = cf_s;
endmodule

// File: rtl/alu_rr_scheduler_arbiter.sv
// Round-robin arbiter: first valid requester at or above ptr wins, with wrap.
// Produces a one-hot grant (or zero) and the winner's binary index.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [SEL_W-1:0] o_idx
);
  logic [N_REQ-1:0] rot_s;
  logic [SEL_W:0]   sum_s;
  logic [SEL_W-1:0] idx_s;
  logic             found_s;

  // Rotate so that bit 0 corresponds to the current priority holder
  assign rot_s = N_REQ'({i_req, i_req} >> i_ptr);

  // Priority-encode the rotated vector and map the winner back to its real index
  always_comb begin
    sum_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found_s && rot_s[i]) begin
        sum_s = {1'b0, i_ptr} + (SEL_W+1)'(i);
        if (sum_s >= (SEL_W+1)'(N_REQ)) begin
          sum_s = sum_s - (SEL_W+1)'(N_REQ);
        end else begin
          sum_s = sum_s;
        end
        idx_s   = SEL_W'(sum_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign o_grant = found_s ? (N_REQ'(1) << idx_s) : '0;
  assign o_idx   = idx_s;
endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational alu among N_REQ requesters with round-robin arbitration,
// registering the result into a one-hot tagged response held until accepted.
module alu_rr_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH    = WORD,
  parameter int OP_WIDTH = OP_W,
  parameter int N_REQ    = N_REQ_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  output logic [N_REQ-1:0]          o_req_ready,
  input  logic [N_REQ*WIDTH-1:0]    i_req_a,
  input  logic [N_REQ*WIDTH-1:0]    i_req_b,
  input  logic [N_REQ*OP_WIDTH-1:0] i_req_op,
  output logic [N_REQ-1:0]          o_rsp_valid,
  input  logic [N_REQ-1:0]          i_rsp_ready,
  output logic [WIDTH-1:0]          o_rsp_result,
  output logic                      o_rsp_zero,
  output logic                      o_rsp_cf,
  output logic                      o_busy
);
  localparam int SEL_W = $clog2(N_REQ);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                zero_q, zero_d;
  logic                cf_q, cf_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;

  logic [N_REQ-1:0]    grant_s;
  logic [SEL_W-1:0]    gidx_s;
  logic                can_accept_s;
  logic                rsp_fire_s;
  logic                req_fire_s;
  logic [WIDTH-1:0]    alu_a_s, alu_b_s, alu_res_s;
  logic [OP_WIDTH-1:0] alu_op_s;
  logic                alu_zero_s, alu_cf_s;

  rr_arbiter #(.N_REQ(N_REQ), .SEL_W(SEL_W)) u_arb (
    .i_req   (i_req_valid),
    .i_ptr   (ptr_q),
    .o_grant (grant_s),
    .o_idx   (gidx_s)
  );

  assign o_rsp_valid = (state_q == ST_RESP) ? owner_q : '0;
  assign rsp_fire_s  = |(o_rsp_valid & i_rsp_ready);

  // A new op may load when nothing is held or the held response retires this cycle
  always_comb begin
    case (state_q)
      ST_IDLE: can_accept_s = 1'b1;
      ST_RESP: can_accept_s = rsp_fire_s;
      default: can_accept_s = 1'b0;
    endcase
  end

  assign o_req_ready = i_rst ? '0 : (grant_s & {N_REQ{can_accept_s}});
  assign req_fire_s  = |(i_req_valid & o_req_ready);

  // One-hot AND-OR mux of the granted requester's operands into the alu
  always_comb begin
    alu_a_s  = '0;
    alu_b_s  = '0;
    alu_op_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      alu_a_s  = alu_a_s  | (i_req_a[k*WIDTH +: WIDTH]        & {WIDTH{grant_s[k]}});
      alu_b_s  = alu_b_s  | (i_req_b[k*WIDTH +: WIDTH]        & {WIDTH{grant_s[k]}});
      alu_op_s = alu_op_s | (i_req_op[k*OP_WIDTH +: OP_WIDTH] & {OP_WIDTH{grant_s[k]}});
    end
  end

  alu #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) u_alu (
    .i_a      (alu_a_s),
    .i_b      (alu_b_s),
    .i_opcode (alu_op_s),
    .o_result (alu_res_s),
    .o_zero   (alu_zero_s),
    .o_cf     (alu_cf_s)
  );

  // Next-state: a fire loads a new response (even as the old one retires); data may go stale in IDLE
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    result_d = result_q;
    zero_d   = zero_q;
    cf_d     = cf_q;
    ptr_d    = ptr_q;
    if (req_fire_s) begin
      state_d  = ST_RESP;
      owner_d  = grant_s;
      result_d = alu_res_s;
      zero_d   = alu_zero_s;
      cf_d     = alu_cf_s;
      ptr_d    = (gidx_s == SEL_W'(N_REQ-1)) ? '0 : (gidx_s + SEL_W'(1));
    end else if (rsp_fire_s) begin
      state_d = ST_IDLE;
      owner_d = '0;
    end else begin
      state_d = state_q;
    end
  end

  // Response register and FSM state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cf_q     <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cf_q     <= cf_d;
      ptr_q    <= ptr_d;
    end
  end

  assign o_rsp_result = result_q;
  assign o_rsp_zero   = zero_q;
  assign o_rsp_cf     = cf_q;
  assign o_busy       = (state_q == ST_RESP);
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational `alu` instance between N_REQ requesters, e.g. the execute stage and the address/branch unit.
- Uses round-robin arbitration with valid/ready handshakes on both the request and response sides.
- Registers the ALU outputs, so each accepted operation returns one cycle later on a shared response bus tagged one-hot per requester.
- Sits between the issue logic and the ALU datapath.

Parameters:
- WIDTH, `WORD, operand/result width passed to `alu`.
- OP_WIDTH, `OP_WIDTH, opcode width passed to `alu`.
- N_REQ, 2, number of requesters; legal range 2..8.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req_valid  input  N_REQ  per-requester request valid.
- o_req_ready  output  N_REQ  per-requester accept; at most one bit set.
- i_req_a  input  N_REQ*WIDTH  operand A; requester k occupies slice [k*WIDTH +: WIDTH].
- i_req_b  input  N_REQ*WIDTH  operand B, same packing as i_req_a.
- i_req_op  input  N_REQ*OP_WIDTH  opcode; requester k occupies slice [k*OP_WIDTH +: OP_WIDTH].
- o_rsp_valid  output  N_REQ  one-hot response valid, addressed to the originating requester.
- i_rsp_ready  input  N_REQ  per-requester response accept.
- o_rsp_result  output  WIDTH  registered ALU result.
- o_rsp_zero  output  1  registered ALU zero flag.
- o_rsp_cf  output  1  registered ALU carry/borrow flag.
- o_busy  output  1  high while a response is held.

Behaviour:
- State machine: IDLE (no response held) and RESP (response register valid). Registers: rsp_owner [N_REQ], one-hot; result/zero/cf; rr_ptr [$clog2(N_REQ)].
- Reset (i_rst high at clock edge) forces:
  - state to IDLE, rr_ptr to 0, rsp_owner to 0;
  - o_rsp_valid, o_rsp_result, o_rsp_zero and o_rsp_cf to 0;
  - o_busy to 0.
- During reset, o_req_ready is forced to 0.
- Reset mid-operation drops any held response silently; requesters must reissue.
- Arbitration:
  - Combinational grant over i_req_valid, searching from index rr_ptr upward with wrap.
  - The first valid requester wins; grant is one-hot or zero.
- Response-release signal rsp_fire = |(o_rsp_valid & i_rsp_ready).
- Accept condition can_accept = (state==IDLE) | rsp_fire.
- o_req_ready = grant & {N_REQ{can_accept}}, combinational from valids and state.
- The request fires for requester g when i_req_valid[g] & o_req_ready[g]. The granted slice drives `alu` i_a/i_b/i_opcode in that same cycle.
- On a request fire, at the next edge:
  - result, zero and cf are registered;
  - rsp_owner <= grant;
  - state <= RESP;
  - rr_ptr <= (g+1) mod N_REQ.
- Latency is 1 cycle from request fire to o_rsp_valid.
- Throughput is 1 op/cycle while responses are accepted on the cycle they appear.
- o_rsp_valid = rsp_owner when state==RESP, else 0.
- While the response is not accepted, result/zero/cf/owner hold stable and no new request is accepted (o_req_ready=0).
- Simultaneous rsp_fire and request fire: the old response retires and the new one loads in the same edge; state stays RESP.
- rsp_fire with no new request: state <= IDLE and rsp_owner <= 0. Data registers may retain stale values.
- rr_ptr advances only on a request fire. A requester that is stalled on i_rsp_ready does not lose its priority position.
- If the ALU is driven with an undefined opcode, the ALU returns result 0, zero 1, cf 0. These values are registered unchanged.
- Request inputs from non-granted requesters are ignored. A requester may deassert valid without penalty before it fires.
- Fairness: with all requesters continuously valid and ready, each is granted once every N_REQ cycles.

Decomposition:
- Shared package/header alu_sched_pkg:
  - state enum {ST_IDLE, ST_RESP};
  - default N_REQ constant;
  - helper constant PTR_W = $clog2(N_REQ).
- Opcodes come from the existing specs.vh `OP_* defines.
- Sub-module rr_arbiter (params N_REQ):
  - inputs req vector and ptr;
  - outputs one-hot grant and binary index of the winner.
- The block instantiates `alu` and rr_arbiter plus the response register and FSM.

Test Plan:
- Reset: hold i_rst 2 cycles with all i_req_valid=1 -> o_req_ready=0, o_rsp_valid=0, o_rsp_result=0, o_busy=0. After release, requester 0 is granted first.
- Single op, WIDTH=8: req0 valid, a=0xF0, b=0x20, `OP_SUM, i_rsp_ready=1 -> next cycle o_rsp_valid=2'b01, result=0x10, cf=1, zero=0.
- Back-to-back round-robin: both valid continuously with rsp_ready=1. Req0 `OP_SUB 5-7, req1 `OP_XOR 0xAA^0xAA -> grants alternate 0,1,0,1. The responses are:
  - req0: result 0xFE, cf=1;
  - req1: result 0x00, zero=1.
- Response backpressure: req0 fires, i_rsp_ready[0]=0 for 3 cycles -> result/flags stable, o_req_ready=0 while req1 valid. On the cycle rsp_ready rises, req1 is accepted the same cycle and its response is valid the next cycle.
- Reset mid-operation: assert i_rst while o_rsp_valid=2'b10 -> next cycle o_rsp_valid=0, rr_ptr back to 0, held result discarded.
- Invalid opcode / `OP_NOP: req1 `OP_NOP a=0x3C -> result 0x3C. An undefined opcode -> result 0, zero=1, cf=0.
